// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the execute-stage branch resolver: op codes, RISC-V
// branch funct3 values and comparator flag bit positions.
package branch_resolve_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_BR   = 2'b01,
    OP_JAL  = 2'b10,
    OP_JALR = 2'b11
  } op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned FLAG_WIDTH = 5;
  localparam int unsigned FLG_EQ  = 4;
  localparam int unsigned FLG_LT  = 3;
  localparam int unsigned FLG_LTU = 2;
  localparam int unsigned FLG_GE  = 1;
  localparam int unsigned FLG_GEU = 0;

endpackage

// File: rtl/branch_resolve_br_cond.sv
// Maps a conditional-branch funct3 plus comparator flags to a taken decision;
// the two unused funct3 codes are reported illegal and never taken.
module br_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic [FLAG_WIDTH-1:0] flag,
  output logic                  taken_c,
  output logic                  illegal_c
);

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (funct3)
      F3_BEQ:  taken_c = flag[FLG_EQ];
      F3_BNE:  taken_c = ~flag[FLG_EQ];
      F3_BLT:  taken_c = flag[FLG_LT];
      F3_BGE:  taken_c = flag[FLG_GE];
      F3_BLTU: taken_c = flag[FLG_LTU];
      F3_BGEU: taken_c = flag[FLG_GEU];
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolver: one registered stage with valid/ready,
// flush, mispredict redirect generation and saturating performance counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_valid,
  output logic                  out_in_ready,
  input  logic [1:0]            in_op,
  input  logic [2:0]            in_funct3,
  input  logic [FLAG_WIDTH-1:0] in_flag,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic                  in_pred_taken,
  input  logic [DATA_WIDTH-1:0] in_pred_target,
  input  logic                  in_flush,
  input  logic                  in_clr_cnt,
  output logic                  out_valid,
  input  logic                  in_out_ready,
  output logic                  out_taken,
  output logic [DATA_WIDTH-1:0] out_target,
  output logic [DATA_WIDTH-1:0] out_link,
  output logic                  out_redirect,
  output logic [DATA_WIDTH-1:0] out_redirect_pc,
  output logic                  out_illegal,
  output logic                  out_misalign,
  output logic [CNT_WIDTH-1:0]  out_br_cnt,
  output logic [CNT_WIDTH-1:0]  out_mis_cnt
);

  localparam logic [DATA_WIDTH-1:0] LINK_OFS = DATA_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  op_e                   op;
  logic                  cond_taken_c;
  logic                  cond_illegal_c;
  logic                  accept_c;
  logic                  taken_c;
  logic                  illegal_c;
  logic                  misalign_c;
  logic                  redirect_c;
  logic [DATA_WIDTH-1:0] jalr_sum_c;
  logic [DATA_WIDTH-1:0] target_c;
  logic [DATA_WIDTH-1:0] link_c;
  logic [DATA_WIDTH-1:0] redirect_pc_c;

  logic                  valid_d, valid_q;
  logic                  taken_d, taken_q;
  logic                  illegal_d, illegal_q;
  logic                  misalign_d, misalign_q;
  logic                  redirect_d, redirect_q;
  logic [DATA_WIDTH-1:0] target_d, target_q;
  logic [DATA_WIDTH-1:0] link_d, link_q;
  logic [DATA_WIDTH-1:0] redirect_pc_d, redirect_pc_q;
  logic [CNT_WIDTH-1:0]  br_cnt_d, br_cnt_q;
  logic [CNT_WIDTH-1:0]  mis_cnt_d, mis_cnt_q;

  assign op = op_e'(in_op);

  br_cond u_br_cond (
    .funct3    (in_funct3),
    .flag      (in_flag),
    .taken_c   (cond_taken_c),
    .illegal_c (cond_illegal_c)
  );

  assign out_in_ready = ~valid_q | in_out_ready;
  assign accept_c     = in_valid & out_in_ready & ~in_flush;

  // Resolve outcome, target and redirect for the request at the stage input.
  always_comb begin
    taken_c    = 1'b0;
    illegal_c  = 1'b0;
    target_c   = '0;
    jalr_sum_c = in_rs1 + in_imm;
    link_c     = in_pc + LINK_OFS;
    case (op)
      OP_BR: begin
        taken_c   = cond_taken_c;
        illegal_c = cond_illegal_c;
        target_c  = in_pc + in_imm;
      end
      OP_JAL: begin
        taken_c  = 1'b1;
        target_c = in_pc + in_imm;
      end
      OP_JALR: begin
        taken_c  = 1'b1;
        target_c = {jalr_sum_c[DATA_WIDTH-1:1], 1'b0};
      end
      default: ;
    endcase
    misalign_c    = taken_c & target_c[1];
    redirect_c    = (op != OP_NONE) &&
                    ((taken_c != in_pred_taken) || (taken_c && (target_c != in_pred_target)));
    redirect_pc_c = taken_c ? target_c : link_c;
  end

  // Pipeline register: flush beats accept; payload holds while stalled.
  always_comb begin
    valid_d       = valid_q;
    taken_d       = taken_q;
    illegal_d     = illegal_q;
    misalign_d    = misalign_q;
    redirect_d    = redirect_q;
    target_d      = target_q;
    link_d        = link_q;
    redirect_pc_d = redirect_pc_q;
    if (in_flush) begin
      valid_d = 1'b0;
    end else if (accept_c) begin
      valid_d = 1'b1;
    end else if (in_out_ready) begin
      valid_d = 1'b0;
    end
    if (accept_c) begin
      taken_d       = taken_c;
      illegal_d     = illegal_c;
      misalign_d    = misalign_c;
      redirect_d    = redirect_c;
      target_d      = target_c;
      link_d        = link_c;
      redirect_pc_d = redirect_pc_c;
    end
  end

  // Saturating counters; clear has priority over a same-cycle increment.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (in_clr_cnt) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else if (accept_c) begin
      if ((op != OP_NONE) && (br_cnt_q != CNT_MAX)) begin
        br_cnt_d = br_cnt_q + CNT_ONE;
      end
      if (redirect_c && (mis_cnt_q != CNT_MAX)) begin
        mis_cnt_d = mis_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      valid_q       <= 1'b0;
      taken_q       <= 1'b0;
      illegal_q     <= 1'b0;
      misalign_q    <= 1'b0;
      redirect_q    <= 1'b0;
      target_q      <= '0;
      link_q        <= '0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      valid_q       <= valid_d;
      taken_q       <= taken_d;
      illegal_q     <= illegal_d;
      misalign_q    <= misalign_d;
      redirect_q    <= redirect_d;
      target_q      <= target_d;
      link_q        <= link_d;
      redirect_pc_q <= redirect_pc_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_taken       = taken_q;
  assign out_illegal     = illegal_q;
  assign out_misalign    = misalign_q;
  assign out_redirect    = redirect_q;
  assign out_target      = target_q;
  assign out_link        = link_q;
  assign out_redirect_pc = redirect_pc_q;
  assign out_br_cnt      = br_cnt_q;
  assign out_mis_cnt     = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected results are queued at accept
// time and compared while the stage presents them; counters use a 4-bit model.
module tb_branch_resolve;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_in_ready;
  logic [1:0]    in_op;
  logic [2:0]    in_funct3;
  logic [4:0]    in_flag;
  logic [DW-1:0] in_pc, in_imm, in_rs1, in_pred_target;
  logic          in_pred_taken, in_flush, in_clr_cnt;
  logic          out_valid, in_out_ready;
  logic          out_taken, out_redirect, out_illegal, out_misalign;
  logic [DW-1:0] out_target, out_link, out_redirect_pc;
  logic [CW-1:0] out_br_cnt, out_mis_cnt;

  typedef struct {
    logic [1:0]    op;
    logic          taken;
    logic [DW-1:0] target;
    logic [DW-1:0] link;
    logic          redirect;
    logic [DW-1:0] rpc;
    logic          illegal;
    logic          misalign;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] m_br  = '0;
  logic [CW-1:0] m_mis = '0;

  always #5 clk = ~clk;

  branch_resolve #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_valid        (in_valid),
    .out_in_ready    (out_in_ready),
    .in_op           (in_op),
    .in_funct3       (in_funct3),
    .in_flag         (in_flag),
    .in_pc           (in_pc),
    .in_imm          (in_imm),
    .in_rs1          (in_rs1),
    .in_pred_taken   (in_pred_taken),
    .in_pred_target  (in_pred_target),
    .in_flush        (in_flush),
    .in_clr_cnt      (in_clr_cnt),
    .out_valid       (out_valid),
    .in_out_ready    (in_out_ready),
    .out_taken       (out_taken),
    .out_target      (out_target),
    .out_link        (out_link),
    .out_redirect    (out_redirect),
    .out_redirect_pc (out_redirect_pc),
    .out_illegal     (out_illegal),
    .out_misalign    (out_misalign),
    .out_br_cnt      (out_br_cnt),
    .out_mis_cnt     (out_mis_cnt)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t r;
    r.op = in_op; r.taken = 1'b0; r.target = '0; r.illegal = 1'b0;
    r.link = in_pc + 64'd4;
    case (in_op)
      2'b01: begin
        r.target = in_pc + in_imm;
        case (in_funct3)
          3'b000: r.taken = in_flag[4];
          3'b001: r.taken = !in_flag[4];
          3'b100: r.taken = in_flag[3];
          3'b101: r.taken = in_flag[1];
          3'b110: r.taken = in_flag[2];
          3'b111: r.taken = in_flag[0];
          default: r.illegal = 1'b1;
        endcase
      end
      2'b10: begin r.taken = 1'b1; r.target = in_pc + in_imm; end
      2'b11: begin r.taken = 1'b1; r.target = (in_rs1 + in_imm) & ~64'd1; end
      default: ;
    endcase
    r.misalign = r.taken && r.target[1];
    r.redirect = (in_op != 2'b00) &&
                 ((r.taken != in_pred_taken) || (r.taken && r.target != in_pred_target));
    r.rpc = r.taken ? r.target : r.link;
    return r;
  endfunction

  // One clock: check ready, predict accept, advance scoreboard, check outputs.
  task automatic cyc();
    logic rdy_exp, acc, xfer;
    exp_t r, f;
    #1;
    rdy_exp = (exp_q.size() == 0) || in_out_ready;
    acc  = 1'b0;
    xfer = 1'b0;
    if (!rst) begin
      check("in_ready", DW'(out_in_ready), DW'(rdy_exp));
      acc  = in_valid && rdy_exp && !in_flush;
      xfer = (exp_q.size() != 0) && in_out_ready;
    end
    r = model();
    @(posedge clk);
    if (rst) begin
      exp_q.delete(); m_br = '0; m_mis = '0;
    end else begin
      if (in_flush) exp_q.delete();
      else begin
        if (xfer) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(r);
      end
      if (in_clr_cnt) begin
        m_br = '0; m_mis = '0;
      end else if (acc) begin
        if (r.op != 2'b00 && m_br != 4'hF) m_br = m_br + 4'd1;
        if (r.redirect && m_mis != 4'hF) m_mis = m_mis + 4'd1;
      end
    end
    #1;
    check("valid", DW'(out_valid), DW'(exp_q.size() != 0));
    check("br_cnt", DW'(out_br_cnt), DW'(m_br));
    check("mis_cnt", DW'(out_mis_cnt), DW'(m_mis));
    if (exp_q.size() != 0) begin
      f = exp_q[0];
      check("taken", DW'(out_taken), DW'(f.taken));
      if (f.op != 2'b00) check("target", out_target, f.target);
      check("link", out_link, f.link);
      check("redirect", DW'(out_redirect), DW'(f.redirect));
      check("redirect_pc", out_redirect_pc, f.rpc);
      check("illegal", DW'(out_illegal), DW'(f.illegal));
      check("misalign", DW'(out_misalign), DW'(f.misalign));
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                       input logic [4:0] fl, input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                       input logic [DW-1:0] rs1, input logic pt, input logic [DW-1:0] ptgt);
    in_valid = v; in_op = op; in_funct3 = f3; in_flag = fl; in_pc = pc; in_imm = imm;
    in_rs1 = rs1; in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  initial begin
    rst = 1'b1; in_flush = 1'b0; in_clr_cnt = 1'b0; in_out_ready = 1'b1;
    drive(1'b1, 2'b10, 3'b000, 5'd0, 64'h100, 64'h8, 64'h0, 1'b0, 64'h0);
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0, 64'h0);
    cyc();

    // BLT taken against a not-taken prediction
    drive(1'b1, 2'b01, 3'b100, 5'b01010, 64'h1000, 64'h40, 64'h0, 1'b0, 64'h0);
    cyc();
    check("blt_target", out_target, 64'h1040);
    check("blt_brcnt", DW'(out_br_cnt), 64'd1);
    in_valid = 1'b0;
    cyc();

    // JALR: bit 0 cleared, correct prediction, bit 1 set
    drive(1'b1, 2'b11, 3'b000, 5'd0, 64'h3000, 64'h4, 64'h2003, 1'b1, 64'h2006);
    cyc();
    check("jalr_target", out_target, 64'h2006);
    check("jalr_misalign", DW'(out_misalign), 64'd1);
    in_valid = 1'b0;
    cyc();

    // Backpressure: hold a BEQ for 3 cycles while new requests wait
    drive(1'b1, 2'b01, 3'b000, 5'b10011, 64'h4000, 64'h20, 64'h0, 1'b1, 64'h4020);
    cyc();
    in_out_ready = 1'b0;
    drive(1'b1, 2'b01, 3'b001, 5'b10011, 64'h5000, 64'h10, 64'h0, 1'b0, 64'h0);
    repeat (3) cyc();
    in_out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();

    // Flush beats a same-cycle request
    drive(1'b1, 2'b10, 3'b000, 5'd0, 64'h6000, 64'h100, 64'h0, 1'b0, 64'h0);
    in_flush = 1'b1;
    cyc();
    in_flush = 1'b0;
    // Illegal funct3 predicted taken
    drive(1'b1, 2'b01, 3'b010, 5'b11111, 64'h7000, 64'h8, 64'h0, 1'b1, 64'h7008);
    cyc();
    check("illegal", DW'(out_illegal), 64'd1);
    drive(1'b1, 2'b01, 3'b011, 5'b00000, 64'h7004, 64'h8, 64'h0, 1'b0, 64'h0);
    cyc();

    // Randomised mix including stalls, flushes and wrap-around sums
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 5'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom), {$urandom, $urandom});
      in_out_ready = 1'($urandom_range(0, 3) != 0);
      in_flush     = 1'($urandom_range(0, 9) == 0);
      cyc();
    end
    in_flush = 1'b0; in_out_ready = 1'b1;

    // Saturation after 20 accepted JALs, then clear with a same-cycle accept
    drive(1'b1, 2'b10, 3'b000, 5'd0, 64'h8000, 64'h40, 64'h0, 1'b0, 64'h0);
    repeat (20) cyc();
    check("br_sat", DW'(out_br_cnt), 64'hF);
    in_clr_cnt = 1'b1;
    cyc();
    in_clr_cnt = 1'b0;
    check("br_clr", DW'(out_br_cnt), 64'h0);

    // Reset while a result is held under backpressure
    in_out_ready = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0; in_out_ready = 1'b1;
    cyc();
    check("rst_valid", DW'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumer end of the comparator flag interface: takes the 5-bit compare flags plus branch/jump context and resolves the taken/not-taken outcome, target, link address and redirect decision.
- Sits in the execute stage between the ALU comparator and the fetch redirect path.
- Single registered pipeline stage with valid/ready handshake, flush, and saturating performance counters.

Parameters:
- DATA_WIDTH, 64, width of PC, immediate, rs1 and target.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- in_clk  input  1  clock.
- in_rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream request valid.
- out_in_ready  output  1  stage can accept this cycle.
- in_op  input  2  operation: 00 none, 01 conditional branch, 10 JAL, 11 JALR.
- in_funct3  input  3  branch condition, RISC-V encoding.
- in_flag  input  5  comparator flags: [4] EQ, [3] LT signed, [2] LT unsigned, [1] GE signed, [0] GE unsigned.
- in_pc  input  DATA_WIDTH  instruction PC.
- in_imm  input  DATA_WIDTH  sign-extended offset.
- in_rs1  input  DATA_WIDTH  JALR base.
- in_pred_taken  input  1  fetch prediction.
- in_pred_target  input  DATA_WIDTH  predicted target.
- in_flush  input  1  kill stage contents.
- in_clr_cnt  input  1  clear counters.
- out_valid  output  1  result valid.
- in_out_ready  input  1  downstream ready.
- out_taken  output  1  resolved outcome.
- out_target  output  DATA_WIDTH  resolved target.
- out_link  output  DATA_WIDTH  pc+4.
- out_redirect  output  1  mispredict; fetch must restart.
- out_redirect_pc  output  DATA_WIDTH  restart PC.
- out_illegal  output  1  funct3 010/011 with op 01.
- out_misalign  output  1  taken and target[1] != 0.
- out_br_cnt  output  CNT_WIDTH  resolved control-flow ops.
- out_mis_cnt  output  CNT_WIDTH  redirects.

Behaviour:
- Reset (in_rst high at a clock edge):
  - out_valid = 0 and all payload outputs = 0.
  - Both counters = 0.
  - out_in_ready = 1 the cycle after.
- Handshake:
  - out_in_ready = !out_valid | in_out_ready, combinational.
  - Accept when in_valid & out_in_ready & !in_flush; the result registers on the next edge, so latency is 1 cycle.
  - While out_valid & !in_out_ready, the payload is held stable.
  - out_valid drops after a transfer when no new accept occurs in the same cycle.
- Condition for op 01:
  - 000 BEQ = EQ; 001 BNE = !EQ.
  - 100 BLT = LT; 101 BGE = GE.
  - 110 BLTU = LTU; 111 BGEU = GEU.
  - 010/011: taken = 0 and out_illegal = 1.
- Op 10/11: taken = 1. Op 00: taken = 0, redirect = 0, all flags 0.
- Target:
  - Ops 01/10: in_pc + in_imm.
  - Op 11: (in_rs1 + in_imm) with bit 0 cleared.
  - All sums are modulo 2^DATA_WIDTH; wrap-around is silent.
- out_link = in_pc + 4, modulo 2^DATA_WIDTH.
- Redirect:
  - Raised when op != 00 and either (taken != in_pred_taken) or (taken & target != in_pred_target).
  - out_redirect_pc = taken ? target : link.
  - Illegal ops redirect only if they were predicted taken.
- out_misalign = taken & target[1]. It is reported only; taken and redirect are unchanged.
- Flush:
  - in_flush clears out_valid at the next edge and drops any same-cycle request. Flush wins over accept.
  - Counters do not count dropped requests.
- Counters:
  - out_br_cnt increments on each accept with op != 00.
  - out_mis_cnt increments on each accept that will raise redirect.
  - Both saturate at all-ones.
  - in_clr_cnt zeroes both; clear wins over a same-cycle increment.
  - in_rst overrides everything.
- Reset asserted mid-transfer: the held result is discarded, with no partial state.

Decomposition:
- Shared package:
  - op encodings OP_NONE/OP_BR/OP_JAL/OP_JALR.
  - funct3 constants F3_BEQ..F3_BGEU.
  - flag bit indices FLG_EQ=4, FLG_LT=3, FLG_LTU=2, FLG_GE=1, FLG_GEU=0.
- One sub-module, br_cond: combinational funct3+flags -> taken/illegal.
- Pipeline register, redirect logic and counters stay in the top.

Test Plan:
- Reset: hold in_rst 2 cycles with in_valid=1 -> out_valid=0, counters 0, out_in_ready=1 after release.
- BLT: pc=0x1000, imm=0x40, flags=5'b01010, pred_taken=0 -> one cycle later taken=1, target=0x1040, redirect=1, redirect_pc=0x1040, br_cnt=1, mis_cnt=1.
- JALR: rs1=0x2003, imm=0x4, pred_taken=1, pred_target=0x2006 -> target=0x2006 (bit 0 cleared), link=pc+4, redirect=0, misalign=1.
- Backpressure: in_out_ready=0 for 3 cycles with a held result -> payload stable, out_in_ready=0, no counter change; then ready=1 with a back-to-back accept -> out_valid stays 1 with the new payload.
- Flush with simultaneous valid: in_flush=1 and in_valid=1 -> out_valid=0 next cycle, counters unchanged; funct3=010 -> illegal=1, taken=0.
- Saturation: preload the counters near all-ones with CNT_WIDTH=4 -> after 20 accepts, br_cnt=4'hF; in_clr_cnt with a same-cycle accept -> 0.
